ucom_rom_loader: RTL and testbench

UCOM_ROM_LOADER -- requirements
Module: ucom_rom_loader

---
 rtl/ucom_pkg.sv | 18 +
 rtl/ucom_rom_loader.sv | 169 ++++++++++++++++
 tb/tb_ucom_rom_loader.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ucom_pkg.sv
// Shared definitions for the microcontroller ROM loader: the FSM state
// encoding and the default complete-image size.
package ucom_pkg;

    localparam int ROM_SIZE_DEF = 2048;
    localparam int COUNT_W      = 12;

    localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_HOLD = 3'd2,
        ST_RUN  = 3'd3,
        ST_ERR  = 3'd4
    } ucom_state_t;

endpackage

// File: rtl/ucom_rom_loader.sv
// Streams a downloaded ROM image into the core's ROM write port and holds the
// core CPU in reset until a complete image has been loaded.
//
// state | meaning
// IDLE  | after reset, no download seen yet, core held in reset
// LOAD  | download in progress, bytes are written and counted
// HOLD  | image complete or soft reset, core held for HOLD_CYCLES
// RUN   | core released
// ERR   | last download was short, core held until a new download
module ucom_rom_loader
    import ucom_pkg::*;
#(
    parameter int ROM_SIZE    = ROM_SIZE_DEF,
    parameter int HOLD_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dl_active,
    input  logic        dl_wr,
    input  logic [15:0] dl_addr,
    input  logic [7:0]  dl_data,
    input  logic        soft_rst,
    output logic        rom_init,
    output logic [11:0] rom_init_addr,
    output logic [7:0]  rom_init_data,
    output logic        cpu_reset,
    output logic        load_ok,
    output logic        load_err,
    output logic        addr_ovf,
    output logic [15:0] checksum
);

    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0]  HOLD_LOAD  = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [COUNT_W-1:0] COUNT_FULL = COUNT_W'(ROM_SIZE);

    ucom_state_t        r_state;
    ucom_state_t        w_state_next;
    logic               r_dl_active_q;
    logic               r_rom_init;
    logic [11:0]        r_rom_init_addr;
    logic [7:0]         r_rom_init_data;
    logic [COUNT_W-1:0] r_count;
    logic [15:0]        r_checksum;
    logic               r_addr_ovf;
    logic               r_load_ok;
    logic               r_load_err;
    logic [HOLD_W-1:0]  r_hold;

    logic w_in_range;
    logic w_dl_rise;
    logic w_accept;
    logic w_ovf_strobe;
    logic w_hold_load;
    logic w_set_ok;
    logic w_set_err;

    assign w_in_range   = ({16'd0, dl_addr} < 32'(ROM_SIZE));
    assign w_dl_rise    = dl_active & ~r_dl_active_q;
    assign w_accept     = dl_active & dl_wr & w_in_range;
    assign w_ovf_strobe = dl_active & dl_wr & ~w_in_range;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A new download overrides every state, including an in-progress hold.
    always_comb begin
        w_state_next = r_state;
        w_hold_load  = 1'b0;
        w_set_ok     = 1'b0;
        w_set_err    = 1'b0;
        if (w_dl_rise) begin
            w_state_next = ST_LOAD;
        end else begin
            case (r_state)
                ST_IDLE: ;
                ST_LOAD: begin
                    if (!dl_active) begin
                        if (r_count == COUNT_FULL) begin
                            w_state_next = ST_HOLD;
                            w_hold_load  = 1'b1;
                        end else begin
                            w_state_next = ST_ERR;
                            w_set_err    = 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (soft_rst) begin
                        w_hold_load = 1'b1;
                    end else if (r_hold == '0) begin
                        w_state_next = ST_RUN;
                        w_set_ok     = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (soft_rst) begin
                        w_state_next = ST_HOLD;
                        w_hold_load  = 1'b1;
                    end
                end
                ST_ERR: ;
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_dl_active_q   <= 1'b0;
            r_rom_init      <= 1'b0;
            r_rom_init_addr <= '0;
            r_rom_init_data <= '0;
            r_count         <= '0;
            r_checksum      <= '0;
            r_addr_ovf      <= 1'b0;
            r_load_ok       <= 1'b0;
            r_load_err      <= 1'b0;
            r_hold          <= '0;
        end else begin
            r_dl_active_q <= dl_active;
            r_rom_init    <= w_accept;
            if (w_accept) begin
                r_rom_init_addr <= {1'b0, dl_addr[10:0]};
                r_rom_init_data <= dl_data;
            end

            // A byte arriving with the rising edge starts the new tally.
            if (w_dl_rise) begin
                r_count    <= w_accept ? COUNT_W'(1) : '0;
                r_checksum <= w_accept ? {8'd0, dl_data} : '0;
                r_addr_ovf <= w_ovf_strobe;
                r_load_ok  <= 1'b0;
                r_load_err <= 1'b0;
            end else begin
                if (w_accept) begin
                    r_checksum <= r_checksum + {8'd0, dl_data};
                    if (r_count != COUNT_MAX) begin
                        r_count <= r_count + COUNT_W'(1);
                    end
                end
                if (w_ovf_strobe) r_addr_ovf <= 1'b1;
                if (w_set_ok)     r_load_ok  <= 1'b1;
                if (w_set_err)    r_load_err <= 1'b1;
            end

            if (w_hold_load) begin
                r_hold <= HOLD_LOAD;
            end else if (r_state == ST_HOLD && r_hold != '0) begin
                r_hold <= r_hold - HOLD_W'(1);
            end
        end
    end

    assign rom_init      = r_rom_init;
    assign rom_init_addr = r_rom_init_addr;
    assign rom_init_data = r_rom_init_data;
    assign cpu_reset     = (r_state != ST_RUN);
    assign load_ok       = r_load_ok;
    assign load_err      = r_load_err;
    assign addr_ovf      = r_addr_ovf;
    assign checksum      = r_checksum;

endmodule

// File: tb/tb_ucom_rom_loader.sv
// Self-checking bench for ucom_rom_loader: vector table for accept/reject
// rules plus sequences for full, short, overflow, soft-reset and reset cases.
module tb_ucom_rom_loader;

    localparam int ROM_SIZE    = 2048;
    localparam int HOLD_CYCLES = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        dl_active = 1'b0;
    logic        dl_wr = 1'b0;
    logic [15:0] dl_addr = '0;
    logic [7:0]  dl_data = '0;
    logic        soft_rst = 1'b0;
    logic        rom_init;
    logic [11:0] rom_init_addr;
    logic [7:0]  rom_init_data;
    logic        cpu_reset;
    logic        load_ok;
    logic        load_err;
    logic        addr_ovf;
    logic [15:0] checksum;

    ucom_rom_loader #(.ROM_SIZE(ROM_SIZE), .HOLD_CYCLES(HOLD_CYCLES)) dut (
        .clk(clk), .reset(reset), .dl_active(dl_active), .dl_wr(dl_wr),
        .dl_addr(dl_addr), .dl_data(dl_data), .soft_rst(soft_rst),
        .rom_init(rom_init), .rom_init_addr(rom_init_addr), .rom_init_data(rom_init_data),
        .cpu_reset(cpu_reset), .load_ok(load_ok), .load_err(load_err),
        .addr_ovf(addr_ovf), .checksum(checksum)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [11:0] addr;
        logic [7:0]  data;
        int          due;
    } wr_t;

    typedef struct {
        logic        act;
        logic        wr;
        logic [15:0] addr;
        logic [7:0]  data;
        logic [15:0] exp_cks;
        logic        exp_ovf;
        logic        exp_err;
    } vec_t;

    wr_t  sb[$];
    vec_t vecs[11];
    int   n_total = 0;
    int   n_pass  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Drive one cycle; every byte the loader should accept is queued with
    // the cycle in which its rom_init pulse is due.
    task automatic step(input logic a, input logic w, input logic [15:0] ad, input logic [7:0] d);
        dl_active = a;
        dl_wr     = w;
        dl_addr   = ad;
        dl_data   = d;
        if (!reset && a && w && ad < 16'(ROM_SIZE))
            sb.push_back('{ad[11:0], d, cyc + 1});
        @(negedge clk);
    endtask

    task automatic run_until_release(output int n, output logic ok_low);
        n = 0;
        ok_low = 1'b0;
        do begin
            step(1'b0, 1'b0, 16'h0, 8'h0);
            n++;
            if (!load_ok) ok_low = 1'b1;
        end while (cpu_reset && n < 200);
    endtask

    always @(negedge clk) begin : monitor
        wr_t e;
        if (rom_init) begin
            n_total++;
            if (sb.size() == 0) begin
                $display("FAIL rom_init: unexpected pulse addr=0x%0h data=0x%0h, expected no pulse",
                         rom_init_addr, rom_init_data);
            end else begin
                e = sb.pop_front();
                if (rom_init_addr === e.addr && rom_init_data === e.data && cyc == e.due)
                    n_pass++;
                else
                    $display("FAIL rom_init write: got addr=0x%0h data=0x%0h cyc=%0d expected addr=0x%0h data=0x%0h cyc=%0d",
                             rom_init_addr, rom_init_data, cyc, e.addr, e.data, e.due);
            end
        end
    end

    initial begin
        logic [15:0] a16;
        logic [15:0] m_sum;
        logic        ok_low;
        logic        ok_low2;
        logic        released;
        int          n;

        vecs[0]  = '{1'b1, 1'b1, 16'h0005, 8'h11, 16'h0011, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 16'h0006, 8'hFF, 16'h0011, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 16'h07FF, 8'hF0, 16'h0101, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 16'h0800, 8'h55, 16'h0101, 1'b1, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 16'hFFFF, 8'h22, 16'h0101, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 16'h0005, 8'h11, 16'h0112, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 16'h0010, 8'h77, 16'h0112, 1'b1, 1'b1};
        vecs[7]  = '{1'b0, 1'b0, 16'h0000, 8'h00, 16'h0112, 1'b1, 1'b1};
        vecs[8]  = '{1'b1, 1'b1, 16'h0100, 8'h80, 16'h0080, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 16'h0900, 8'h01, 16'h0080, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 16'h0000, 8'h00, 16'h0080, 1'b1, 1'b1};

        repeat (3) @(negedge clk);
        check("reset cpu_reset", 32'(cpu_reset), 32'd1);
        check("reset rom_init", 32'(rom_init), 32'd0);
        check("reset rom_init_addr", 32'(rom_init_addr), 32'd0);
        check("reset rom_init_data", 32'(rom_init_data), 32'd0);
        check("reset checksum", 32'(checksum), 32'd0);
        check("reset flags", {29'd0, load_ok, load_err, addr_ovf}, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 11; i++) begin
            step(vecs[i].act, vecs[i].wr, vecs[i].addr, vecs[i].data);
            check($sformatf("vec%0d checksum", i), 32'(checksum), 32'(vecs[i].exp_cks));
            check($sformatf("vec%0d addr_ovf", i), 32'(addr_ovf), 32'(vecs[i].exp_ovf));
            check($sformatf("vec%0d load_err", i), 32'(load_err), 32'(vecs[i].exp_err));
        end

        // Full image, data = addr[7:0]
        m_sum = '0;
        for (int i = 0; i < ROM_SIZE; i++) begin
            a16 = 16'(i);
            step(1'b1, 1'b1, a16, a16[7:0]);
            m_sum = m_sum + {8'd0, a16[7:0]};
        end
        step(1'b0, 1'b0, 16'h0, 8'h0);
        check("full checksum", 32'(checksum), 32'(m_sum));
        check("full cpu_reset in hold", 32'(cpu_reset), 32'd1);
        run_until_release(n, ok_low);
        check("full hold cycles from hold entry", 32'(n), 32'(HOLD_CYCLES));
        check("full flags ok/err/ovf", {29'd0, load_ok, load_err, addr_ovf}, 32'b100);

        // Soft reset held for 5 cycles while running
        soft_rst = 1'b1;
        step(1'b0, 1'b0, 16'h0, 8'h0);
        check("soft cpu_reset rises", 32'(cpu_reset), 32'd1);
        ok_low = !load_ok;
        repeat (4) begin
            step(1'b0, 1'b0, 16'h0, 8'h0);
            if (!load_ok) ok_low = 1'b1;
        end
        check("soft cpu_reset held", 32'(cpu_reset), 32'd1);
        soft_rst = 1'b0;
        run_until_release(n, ok_low2);
        check("soft release after fall", 32'(n), 32'(HOLD_CYCLES));
        check("soft load_ok kept", 32'(ok_low | ok_low2), 32'd0);

        // Full image followed by an out-of-range byte
        m_sum = '0;
        for (int i = 0; i < ROM_SIZE; i++) begin
            a16 = 16'(i);
            step(1'b1, 1'b1, a16, ~a16[7:0]);
            m_sum = m_sum + {8'd0, ~a16[7:0]};
        end
        step(1'b1, 1'b1, 16'h0800, 8'hAA);
        step(1'b0, 1'b0, 16'h0, 8'h0);
        check("ovf addr_ovf", 32'(addr_ovf), 32'd1);
        check("ovf checksum", 32'(checksum), 32'(m_sum));
        run_until_release(n, ok_low);
        check("ovf hold cycles", 32'(n), 32'(HOLD_CYCLES));
        check("ovf reaches run", {30'd0, cpu_reset, load_ok}, 32'b01);

        // New download while running
        step(1'b1, 1'b0, 16'h0, 8'h0);
        check("reload cpu_reset", 32'(cpu_reset), 32'd1);
        check("reload checksum cleared", 32'(checksum), 32'd0);
        check("reload flags cleared", {29'd0, load_ok, load_err, addr_ovf}, 32'd0);
        m_sum = '0;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b1, 16'(i), 8'h5A);
            m_sum = m_sum + 16'h005A;
        end
        check("reload partial checksum", 32'(checksum), 32'(m_sum));

        // Reset in the middle of a download
        reset = 1'b1;
        step(1'b0, 1'b0, 16'h0, 8'h0);
        step(1'b0, 1'b0, 16'h0, 8'h0);
        reset = 1'b0;
        step(1'b0, 1'b0, 16'h0, 8'h0);
        check("midload reset cpu_reset", 32'(cpu_reset), 32'd1);
        check("midload reset checksum", 32'(checksum), 32'd0);
        check("midload reset flags", {28'd0, rom_init, load_ok, load_err, addr_ovf}, 32'd0);
        repeat (10) step(1'b0, 1'b0, 16'h0, 8'h0);
        check("idle stays idle", {30'd0, cpu_reset, load_err}, 32'b10);

        // Reset released with a download already active
        reset = 1'b1;
        step(1'b1, 1'b1, 16'h0003, 8'h09);
        step(1'b1, 1'b1, 16'h0003, 8'h09);
        reset = 1'b0;
        step(1'b1, 1'b1, 16'h0003, 8'h09);
        check("active at reset release checksum", 32'(checksum), 32'h9);
        step(1'b0, 1'b0, 16'h0, 8'h0);
        check("active at reset release short", 32'(load_err), 32'd1);

        // Short image
        for (int i = 0; i < 2000; i++) begin
            a16 = 16'(i);
            step(1'b1, 1'b1, a16, a16[7:0]);
        end
        step(1'b0, 1'b0, 16'h0, 8'h0);
        check("short load_err", 32'(load_err), 32'd1);
        released = 1'b0;
        soft_rst = 1'b1;
        repeat (10) begin
            step(1'b0, 1'b0, 16'h0, 8'h0);
            if (!cpu_reset) released = 1'b1;
        end
        soft_rst = 1'b0;
        repeat (30) begin
            step(1'b0, 1'b0, 16'h0, 8'h0);
            if (!cpu_reset) released = 1'b1;
        end
        check("short never released", 32'(released), 32'd0);
        check("short load_ok", 32'(load_ok), 32'd0);

        repeat (2) step(1'b0, 1'b0, 16'h0, 8'h0);
        check("all expected writes seen", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
